// File: rtl/uart_tx_feeder_if.sv
// Handshake bundle between the TX feeder, the TX FIFO read port and the UART transmitter.
// Signal prefixes are relative to the feeder: i_* flow into it, o_* flow out of it.
interface uart_tx_feeder_if;
    logic       i_fifo_empty;
    logic       o_fifo_rd;
    logic [7:0] i_fifo_rdata;
    logic       o_valid;
    logic       i_ready;
    logic [8:0] o_data;
    logic       i_tx_status;

    modport master (
        input  i_fifo_empty,
        input  i_fifo_rdata,
        input  i_ready,
        input  i_tx_status,
        output o_fifo_rd,
        output o_valid,
        output o_data
    );

    modport slave (
        output i_fifo_empty,
        output i_fifo_rdata,
        output i_ready,
        output i_tx_status,
        input  o_fifo_rd,
        input  o_valid,
        input  o_data
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Fetches one byte at a time from the TX FIFO, appends parity, offers it to the transmitter,
// then waits out the transmitted frame plus a programmable idle gap before the next fetch.
module uart_tx_feeder #(
    parameter int GAP_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_enable,
    input  logic [1:0]           i_parity_mode,
    input  logic [GAP_W-1:0]     i_gap_cycles,
    uart_tx_feeder_if.master     bus,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_CAPTURE,
        S_OFFER,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [8:0]         data_q, data_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               par_bit;
    logic               fifo_rd;
    logic               valid;
    logic               busy;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Enable and FIFO-empty only matter when deciding to start a new word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (i_enable && !bus.i_fifo_empty) state_d = S_POP;
            S_POP:       state_d = S_CAPTURE;
            S_CAPTURE:   state_d = S_OFFER;
            S_OFFER:     if (bus.i_ready) state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (bus.i_tx_status) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (!bus.i_tx_status) state_d = S_GAP;
            S_GAP:       if (gap_q == '0) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        par_bit = 1'b0;
        case (i_parity_mode)
            2'd0:    par_bit = ^bus.i_fifo_rdata;
            2'd1:    par_bit = ~^bus.i_fifo_rdata;
            2'd2:    par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
        case (state_q)
            S_CAPTURE:   data_d = {par_bit, bus.i_fifo_rdata};
            S_OFFER:     if (bus.i_ready) cnt_d = cnt_q + CNT_W'(1);
            S_WAIT_DONE: if (!bus.i_tx_status) gap_d = i_gap_cycles;
            S_GAP:       if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
            default:     ;
        endcase
    end

    always_comb begin
        fifo_rd = 1'b0;
        valid   = 1'b0;
        busy    = 1'b1;
        case (state_q)
            S_IDLE:  busy    = 1'b0;
            S_POP:   fifo_rd = 1'b1;
            S_OFFER: valid   = 1'b1;
            default: ;
        endcase
    end

    assign bus.o_fifo_rd = fifo_rd;
    assign bus.o_valid   = valid;
    assign bus.o_data    = data_q;
    assign o_busy        = busy;
    assign o_frame_cnt   = cnt_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: behavioural FIFO with 1-cycle read latency and a
// transmitter model that holds status high for TX_LEN cycles after each accepted word.
module tb_uart_tx_feeder;
    localparam int GAP_W  = 32;
    localparam int CNT_W  = 4;
    localparam int TX_LEN = 10;

    localparam int W_VALID = 0;
    localparam int W_STAT  = 1;
    localparam int W_RD    = 2;
    localparam int W_BUSY  = 3;
    localparam int W_IDLE  = 4;

    logic               clk = 1'b0;
    logic               nrst;
    logic               enable;
    logic [1:0]         pmode;
    logic [GAP_W-1:0]   gap;
    logic               busy;
    logic [CNT_W-1:0]   frame_cnt;

    uart_tx_feeder_if bus_if();

    uart_tx_feeder #(.GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_nrst        (nrst),
        .i_enable      (enable),
        .i_parity_mode (pmode),
        .i_gap_cycles  (gap),
        .bus           (bus_if),
        .o_busy        (busy),
        .o_frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_mem [0:63];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int pops    = 0;
    int tx_left = 0;
    int total   = 0;
    int bad     = 0;

    assign bus_if.i_fifo_empty = (wr_ptr == rd_ptr);
    assign bus_if.i_tx_status  = (tx_left > 0);

    always @(posedge clk) begin
        if (bus_if.o_fifo_rd) begin
            bus_if.i_fifo_rdata <= fifo_mem[rd_ptr[5:0]];
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
        if (bus_if.o_valid && bus_if.i_ready)
            tx_left <= TX_LEN;
        else if (tx_left > 0)
            tx_left <= tx_left - 1;
    end

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Advance negedge by negedge until the selected signal reaches level; n = edges waited.
    task automatic wait_sig(input int which, input logic level, input int bound,
                            input string tag, output int n);
        logic s;
        bit   done;
        n    = 0;
        done = 1'b0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
            case (which)
                W_VALID: s = bus_if.o_valid;
                W_STAT:  s = bus_if.i_tx_status;
                W_RD:    s = bus_if.o_fifo_rd;
                W_BUSY:  s = busy;
                default: s = !busy && bus_if.i_fifo_empty;
            endcase
            if (s === level) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: signal still not %0b after %0d cycles", tag, level, n);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) tick();
        total++; if (bus_if.o_fifo_rd !== 1'b0) begin bad++; $display("FAIL rst_fifo_rd: got %b want 0", bus_if.o_fifo_rd); end
        total++; if (bus_if.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus_if.o_valid); end
        total++; if (bus_if.o_data !== 9'h000) begin bad++; $display("FAIL rst_data: got %h want 000", bus_if.o_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (frame_cnt !== 4'd0) begin bad++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        int p0;
        enable = 1'b1; pmode = 2'd0; gap = '0; bus_if.i_ready = 1'b1;
        p0 = pops;
        push(8'hA5);
        wait_sig(W_VALID, 1'b1, 20, "valid_a5", n);
        total++; if (n !== 3) begin bad++; $display("FAIL latency_a5: got %0d cycles want 3", n); end
        total++; if (bus_if.o_data !== 9'h0A5) begin bad++; $display("FAIL data_a5: got %h want 0a5", bus_if.o_data); end
        tick();
        total++; if (frame_cnt !== 4'd1) begin bad++; $display("FAIL cnt_a5: got %0d want 1", frame_cnt); end
        push(8'h3C);
        wait_sig(W_STAT, 1'b1, 20, "stat_hi_a5", n);
        wait_sig(W_STAT, 1'b0, 30, "stat_lo_a5", n);
        total++; if (pops - p0 !== 1) begin bad++; $display("FAIL pops_a5: got %0d want 1", pops - p0); end
        // status low seen here -> WAIT_DONE exits next edge, 1 GAP cycle, 1 IDLE cycle, then POP
        wait_sig(W_RD, 1'b1, 20, "pop_3c", n);
        total++; if (n !== 3) begin bad++; $display("FAIL gap0_pop_delay: got %0d want 3", n); end
        tick();
        total++; if (bus_if.o_fifo_rd !== 1'b0) begin bad++; $display("FAIL pop_width: got %b want 0", bus_if.o_fifo_rd); end
        wait_sig(W_IDLE, 1'b1, 100, "idle_basic", n);
    endtask

    task automatic test_parity();
        int n;
        logic [3:0] par_exp;
        logic [8:0] exp_data;
        par_exp = 4'b0101;
        for (int m = 0; m < 4; m++) begin
            pmode = m[1:0];
            push(8'h07);
            wait_sig(W_VALID, 1'b1, 20, "valid_par", n);
            exp_data = {par_exp[m], 8'h07};
            total++; if (bus_if.o_data !== exp_data) begin bad++; $display("FAIL parity_mode%0d: got %h want %h", m, bus_if.o_data, exp_data); end
            wait_sig(W_IDLE, 1'b1, 100, "idle_par", n);
        end
        pmode = 2'd0;
    endtask

    task automatic test_backpressure();
        int n;
        int p0;
        bit hold_ok;
        logic [CNT_W-1:0] c0;
        logic [CNT_W-1:0] c_exp;
        bus_if.i_ready = 1'b0;
        pmode = 2'd1;
        push(8'h5A);
        push(8'h11);
        wait_sig(W_VALID, 1'b1, 20, "valid_bp", n);
        p0 = pops;
        c0 = frame_cnt;
        hold_ok = 1'b1;
        repeat (50) begin
            tick();
            if (!(bus_if.o_valid === 1'b1 && bus_if.o_data === 9'h15A)) hold_ok = 1'b0;
        end
        total++; if (!hold_ok) begin bad++; $display("FAIL bp_hold: valid=%b data=%h want 1/15a", bus_if.o_valid, bus_if.o_data); end
        total++; if (pops !== p0) begin bad++; $display("FAIL bp_no_pop: got %0d pops want %0d", pops, p0); end
        c_exp = c0;
        total++; if (frame_cnt !== c_exp) begin bad++; $display("FAIL bp_cnt_hold: got %0d want %0d", frame_cnt, c_exp); end
        bus_if.i_ready = 1'b1;
        tick();
        c_exp = c0 + 4'd1;
        total++; if (frame_cnt !== c_exp) begin bad++; $display("FAIL bp_cnt_release: got %0d want %0d", frame_cnt, c_exp); end
        total++; if (bus_if.o_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop: got %b want 0", bus_if.o_valid); end
        wait_sig(W_IDLE, 1'b1, 100, "idle_bp", n);
        c_exp = c0 + 4'd2;
        total++; if (frame_cnt !== c_exp) begin bad++; $display("FAIL bp_cnt_second: got %0d want %0d", frame_cnt, c_exp); end
        pmode = 2'd0;
    endtask

    task automatic test_gap();
        int n;
        gap = 32'd100;
        push(8'h01);
        push(8'h02);
        wait_sig(W_VALID, 1'b1, 20, "valid_gap", n);
        wait_sig(W_STAT, 1'b1, 20, "stat_hi_gap", n);
        wait_sig(W_STAT, 1'b0, 30, "stat_lo_gap", n);
        // 1 edge to leave WAIT_DONE, 101 GAP cycles, 1 IDLE cycle before POP shows
        wait_sig(W_RD, 1'b1, 200, "pop_gap", n);
        total++; if (n !== 103) begin bad++; $display("FAIL gap100_pop_delay: got %0d want 103", n); end
        gap = '0;
        wait_sig(W_IDLE, 1'b1, 400, "idle_gap", n);
    endtask

    task automatic test_enable_drop();
        int n;
        int p0;
        bit quiet;
        push(8'h44);
        wait_sig(W_STAT, 1'b1, 20, "stat_hi_en", n);
        tick();
        enable = 1'b0;
        push(8'h99);
        wait_sig(W_BUSY, 1'b0, 50, "idle_en", n);
        p0 = pops;
        quiet = 1'b1;
        repeat (20) begin
            tick();
            if (busy !== 1'b0 || bus_if.o_fifo_rd !== 1'b0) quiet = 1'b0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL en_quiet: busy=%b rd=%b want 0/0", busy, bus_if.o_fifo_rd); end
        total++; if (pops !== p0) begin bad++; $display("FAIL en_no_pop: got %0d pops want %0d", pops, p0); end
        enable = 1'b1;
        wait_sig(W_VALID, 1'b1, 20, "valid_en", n);
        total++; if (bus_if.o_data !== 9'h099) begin bad++; $display("FAIL en_data: got %h want 099", bus_if.o_data); end
        wait_sig(W_IDLE, 1'b1, 100, "idle_en2", n);
    endtask

    task automatic test_reset_mid();
        int n;
        int p0;
        bus_if.i_ready = 1'b0;
        push(8'hC3);
        wait_sig(W_VALID, 1'b1, 20, "valid_rst", n);
        p0 = pops;
        #2 nrst = 1'b0;
        #1;
        total++; if (bus_if.o_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", bus_if.o_valid); end
        total++; if (bus_if.o_data !== 9'h000) begin bad++; $display("FAIL arst_data: got %h want 000", bus_if.o_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
        total++; if (frame_cnt !== 4'd0) begin bad++; $display("FAIL arst_cnt: got %0d want 0", frame_cnt); end
        total++; if (bus_if.o_fifo_rd !== 1'b0) begin bad++; $display("FAIL arst_fifo_rd: got %b want 0", bus_if.o_fifo_rd); end
        tick();
        tick();
        nrst = 1'b1;
        bus_if.i_ready = 1'b1;
        push(8'h96);
        wait_sig(W_VALID, 1'b1, 20, "valid_post_rst", n);
        total++; if (bus_if.o_data !== 9'h096) begin bad++; $display("FAIL post_rst_data: got %h want 096", bus_if.o_data); end
        total++; if (pops - p0 !== 1) begin bad++; $display("FAIL post_rst_pops: got %0d want 1", pops - p0); end
        wait_sig(W_IDLE, 1'b1, 100, "idle_post_rst", n);
        total++; if (frame_cnt !== 4'd1) begin bad++; $display("FAIL post_rst_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_wrap();
        int n;
        for (int i = 0; i < 14; i++) begin
            push(8'h20 + 8'(i));
        end
        wait_sig(W_IDLE, 1'b1, 1000, "idle_wrap14", n);
        total++; if (frame_cnt !== 4'hF) begin bad++; $display("FAIL wrap_cnt15: got %0d want 15", frame_cnt); end
        push(8'hFF);
        wait_sig(W_IDLE, 1'b1, 100, "idle_wrap16", n);
        total++; if (frame_cnt !== 4'h0) begin bad++; $display("FAIL wrap_cnt16: got %0d want 0", frame_cnt); end
    endtask

    initial begin
        nrst           = 1'b0;
        enable         = 1'b0;
        pmode          = 2'd0;
        gap            = '0;
        bus_if.i_ready = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_backpressure();
        test_gap();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
